lii_rx_unpack: RTL and testbench
================================

Name: lii_rx_unpack

Overview:
- Receive-side counterpart of the kernel output packer: consumes one LII phy input channel and feeds a 16-bit HLS kernel input stream.
- Filters flits by destination node ID, unpacks the low DW bits of each accepted flit into a small elastic FIFO, and presents them to the kernel with a clock-enable.
- Sits directly downstream of the LII link that carries an upstream kernel's packed output.

Parameters:
- PW, 64, LII packing width (flit data bits).
- DW, 16, kernel stream data width; DW <= PW.
- NODE_ID, 8'h00, destination ID this block accepts.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CHECK_SRC, 0, when 1 also require src == SRC_ID.
- SRC_ID, 8'h00, expected source ID (used only when CHECK_SRC = 1).

Ports:
- aclk  in  1  clock.
- arstn  in  1  asynchronous active-low reset.
- lii_in_p0_tdata  in  PW  flit data; payload in [DW-1:0].
- lii_in_p0_tvalid  in  1  flit valid.
- lii_in_p0_tready  out  1  flit ready.
- lii_in_p0_src  in  8  flit source ID.
- lii_in_p0_dst  in  8  flit destination ID.
- img_stream_tdata  out  DW  kernel input data.
- img_stream_tvalid  out  1  kernel input valid.
- img_stream_tready  in  1  kernel ready.
- ce  out  1  kernel clock enable.
- drop_count  out  16  count of discarded flits, saturating.
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (arstn low, asynchronous): FIFO pointers, occupancy and drop_count cleared; lii_in_p0_tready=0, img_stream_tvalid=0, ce=0, fifo_level=0. img_stream_tdata is don't-care while tvalid=0.
- Reset mid-operation: all FIFO contents are discarded; no partial flit survives.
- Ready bring-up: lii_in_p0_tready comes from a registered enable flag. The flag is 0 in reset and is set on the first aclk edge after arstn deasserts. From then on, tready = flag & !full.
- Input handshake: a flit transfers when tvalid & tready. A producer holding tvalid while tready=0 loses nothing.
- Match condition: dst == NODE_ID, and additionally src == SRC_ID when CHECK_SRC = 1.
- Matching flit: tdata[DW-1:0] is written at the write pointer; upper bits are ignored.
- Non-matching flit: the flit is still accepted (tready unaffected) and discarded. drop_count increments by 1 and saturates at 16'hFFFF.
- Output: img_stream_tvalid = !empty; img_stream_tdata = FIFO head (read directly from storage, no extra register). A pop occurs on img_stream_tvalid & img_stream_tready.
- Latency: a matching flit accepted at edge N appears at the output with tvalid=1 after edge N (one cycle), provided the FIFO was empty.
- Throughput: one flit per cycle in and one word per cycle out, sustained.
- Simultaneous push and pop: pointers both advance; fifo_level is unchanged. At full, tready=0, so no push occurs even when a pop happens in the same cycle (no bypass). Tready rises on the following cycle.
- Empty: a pop is impossible (tvalid=0). A dropped flit never changes fifo_level.
- Pointers: $clog2(DEPTH) bits plus one wrap bit. Full is indicated when the addresses are equal and the wrap bits differ. Wrap-around is natural modulo DEPTH.
- ce = img_stream_tvalid (kernel advances only when input data is present); combinational from occupancy.
- Ordering: accepted words leave in arrival order; no reordering and no duplication.

Decomposition:
- Shared package lii_pkg: LII_ID_W=8, default PW=64, and the node-ID constants for the design.
- One natural sub-module: lii_sync_fifo (parameterised width and depth; push/pop/full/empty/level). It is reusable by the transmit side.
- The top level holds the ID filter, ready flag, drop counter and ce.

Test Plan:
- Reset then single flit: release arstn; tready=0 in cycle 0 and 1 from the next edge. Send tdata=64'hDEAD_BEEF_0000_1234, dst=NODE_ID -> next cycle img_stream_tdata=16'h1234, tvalid=1, ce=1, fifo_level=1.
- Fill with kernel stalled: img_stream_tready=0; send 6 matching flits with payloads 1..6, DEPTH=4 -> payloads 1..4 stored, tready=0, fifo_level=4. Release the stall -> outputs 1,2,3,4,5,6 in order, no loss.
- Address filter: interleave dst=NODE_ID (payloads 10, 11) with dst=NODE_ID+1 (payloads 99, 98) -> only 10, 11 are output; drop_count=2; tready stays 1 throughout.
- Streaming with wrap: tvalid=1 and img_stream_tready=1 continuously for 20 flits, payloads 0..19 -> 20 outputs in order, fifo_level stays at 1, pointers wrap at least 4 times.
- Reset mid-stream: fifo_level=3, assert arstn for 1 cycle -> tvalid=0, ce=0, fifo_level=0, drop_count=0 immediately. The old words are never output; the next flit is accepted normally.
- Drop saturation and src check: CHECK_SRC=1, SRC_ID=8'h05; force drop_count to 16'hFFFE, send 3 flits with dst=NODE_ID, src=8'h06 -> drop_count=16'hFFFF (held), no output. A flit with src=8'h05 is delivered.

Source files
------------

// File: rtl/lii_pkg.sv
// Shared LII link definitions: ID width, default packing width, node IDs and
// the routing-match helper used by both directions of the link.
package lii_pkg;

    localparam int LII_ID_W       = 8;
    localparam int LII_PW_DEFAULT = 64;

    typedef logic [LII_ID_W-1:0] lii_id_t;

    // Node IDs assigned on the link; the rx block defaults to the first.
    localparam lii_id_t LII_NODE_KERNEL0 = 8'h00;
    localparam lii_id_t LII_NODE_KERNEL1 = 8'h01;
    localparam lii_id_t LII_NODE_HOST    = 8'hF0;

    typedef struct packed {
        lii_id_t src;
        lii_id_t dst;
    } lii_route_t;

    function automatic logic lii_route_match(
        input lii_route_t route,
        input lii_id_t    node_id,
        input logic       check_src,
        input lii_id_t    src_id
    );
        return (route.dst == node_id) && (!check_src || (route.src == src_id));
    endfunction

endpackage

// File: rtl/lii_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; head is read straight from storage.
// Push is ignored when full and pop when empty, so callers may gate loosely.
module lii_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; empty pointers already mask
    // stale entries, and leaving it unreset lets the array map onto RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/lii_rx_unpack.sv
// LII receive unpacker: filters flits by node ID, buffers the low DW payload
// bits and streams them to the kernel with a matching clock-enable.
module lii_rx_unpack
    import lii_pkg::*;
#(
    parameter int      PW        = LII_PW_DEFAULT,
    parameter int      DW        = 16,
    parameter lii_id_t NODE_ID   = LII_NODE_KERNEL0,
    parameter int      DEPTH     = 4,
    parameter int      CHECK_SRC = 0,
    parameter lii_id_t SRC_ID    = 8'h00
) (
    input  logic                       aclk,
    input  logic                       arstn,
    input  logic [PW-1:0]              lii_in_p0_tdata,
    input  logic                       lii_in_p0_tvalid,
    output logic                       lii_in_p0_tready,
    input  logic [LII_ID_W-1:0]        lii_in_p0_src,
    input  logic [LII_ID_W-1:0]        lii_in_p0_dst,
    output logic [DW-1:0]              img_stream_tdata,
    output logic                       img_stream_tvalid,
    input  logic                       img_stream_tready,
    output logic                       ce,
    output logic [15:0]                drop_count,
    output logic [$clog2(DEPTH):0]     fifo_level
);

    logic       ready_en_q;
    logic       fifo_full, fifo_empty;
    logic       accept, match, push, drop, pop;
    logic [15:0] drop_q, drop_d;
    lii_route_t route;

    // Upper flit bits carry nothing for this kernel.
    if (PW > DW) begin : g_unused_hi
        logic unused_tdata_hi;
        assign unused_tdata_hi = ^lii_in_p0_tdata[PW-1:DW];
    end

    // Held low through reset so the upstream link sees no ready until one
    // clean edge after release.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) ready_en_q <= 1'b0;
        else        ready_en_q <= 1'b1;
    end

    assign lii_in_p0_tready = ready_en_q && !fifo_full;

    assign route  = '{src: lii_in_p0_src, dst: lii_in_p0_dst};
    assign match  = lii_route_match(route, NODE_ID, CHECK_SRC != 0, SRC_ID);
    assign accept = lii_in_p0_tvalid && lii_in_p0_tready;
    assign push   = accept && match;
    assign drop   = accept && !match;
    assign pop    = img_stream_tvalid && img_stream_tready;

    // NOTE: combinational next-state uses blocking '=' with a default first,
    // so every path assigns drop_d and no latch is inferred.
    always_comb begin
        drop_d = drop_q;
        if (drop && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
    end

    // NOTE: state registers use non-blocking '<=' so all flops update together.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) drop_q <= 16'h0000;
        else        drop_q <= drop_d;
    end

    lii_sync_fifo #(
        .WIDTH (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (aclk),
        .rst_n   (arstn),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (lii_in_p0_tdata[DW-1:0]),
        .rdata_o (img_stream_tdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign img_stream_tvalid = !fifo_empty;
    assign ce                = !fifo_empty;
    assign drop_count        = drop_q;

endmodule

// File: tb/tb_lii_rx_unpack.sv
// Directed bench for lii_rx_unpack: vector table for the basic flows plus
// hand sequences for streaming wrap, mid-stream reset and drop saturation.
module tb_lii_rx_unpack;

    logic        aclk = 1'b0;
    logic        arstn;

    logic [63:0] tdata;
    logic        tvalid;
    logic        tready;
    logic [7:0]  src, dst;
    logic [15:0] o_data;
    logic        o_valid, o_ready, o_ce;
    logic [15:0] o_drop;
    logic [2:0]  o_level;

    logic [63:0] s_tdata;
    logic        s_tvalid, s_tready;
    logic [7:0]  s_src, s_dst;
    logic [15:0] s_odata;
    logic        s_ovalid, s_oready, s_ce;
    logic [15:0] s_drop;
    logic [2:0]  s_level;

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    lii_rx_unpack dut (
        .aclk (aclk), .arstn (arstn),
        .lii_in_p0_tdata (tdata), .lii_in_p0_tvalid (tvalid), .lii_in_p0_tready (tready),
        .lii_in_p0_src (src), .lii_in_p0_dst (dst),
        .img_stream_tdata (o_data), .img_stream_tvalid (o_valid), .img_stream_tready (o_ready),
        .ce (o_ce), .drop_count (o_drop), .fifo_level (o_level)
    );

    lii_rx_unpack #(.CHECK_SRC (1), .SRC_ID (8'h05)) u_src (
        .aclk (aclk), .arstn (arstn),
        .lii_in_p0_tdata (s_tdata), .lii_in_p0_tvalid (s_tvalid), .lii_in_p0_tready (s_tready),
        .lii_in_p0_src (s_src), .lii_in_p0_dst (s_dst),
        .img_stream_tdata (s_odata), .img_stream_tvalid (s_ovalid), .img_stream_tready (s_oready),
        .ce (s_ce), .drop_count (s_drop), .fifo_level (s_level)
    );

    typedef struct {
        logic        valid;
        logic [7:0]  dst;
        logic [63:0] data;
        logic        rdy;
        logic        e_tready;
        logic        e_tvalid;
        logic [15:0] e_tdata;
        logic [2:0]  e_level;
        logic [15:0] e_drop;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge aclk);
        #1;
    endtask

    task automatic check_main(input string tag, input logic e_tready, input logic e_tvalid,
                              input logic [15:0] e_tdata, input logic [2:0] e_level,
                              input logic [15:0] e_drop);
        check({tag, " tready"}, 64'(tready), 64'(e_tready));
        check({tag, " tvalid"}, 64'(o_valid), 64'(e_tvalid));
        check({tag, " ce"}, 64'(o_ce), 64'(e_tvalid));
        check({tag, " level"}, 64'(o_level), 64'(e_level));
        check({tag, " drop"}, 64'(o_drop), 64'(e_drop));
        if (e_tvalid) check({tag, " tdata"}, 64'(o_data), 64'(e_tdata));
    endtask

    vec_t vecs [19];

    initial begin
        vecs = '{
            // single flit, upper bits ignored
            '{1'b1, 8'h00, 64'hDEAD_BEEF_0000_1234, 1'b0, 1'b1, 1'b1, 16'h1234, 3'd1, 16'd0},
            '{1'b0, 8'h00, 64'h0,                   1'b1, 1'b1, 1'b0, 16'h0000, 3'd0, 16'd0},
            // fill with kernel stalled, producer holds flit 5
            '{1'b1, 8'h00, 64'd1, 1'b0, 1'b1, 1'b1, 16'd1, 3'd1, 16'd0},
            '{1'b1, 8'h00, 64'd2, 1'b0, 1'b1, 1'b1, 16'd1, 3'd2, 16'd0},
            '{1'b1, 8'h00, 64'd3, 1'b0, 1'b1, 1'b1, 16'd1, 3'd3, 16'd0},
            '{1'b1, 8'h00, 64'd4, 1'b0, 1'b0, 1'b1, 16'd1, 3'd4, 16'd0},
            '{1'b1, 8'h00, 64'd5, 1'b0, 1'b0, 1'b1, 16'd1, 3'd4, 16'd0},
            // release: full edge pops only, then push+pop
            '{1'b1, 8'h00, 64'd5, 1'b1, 1'b1, 1'b1, 16'd2, 3'd3, 16'd0},
            '{1'b1, 8'h00, 64'd5, 1'b1, 1'b1, 1'b1, 16'd3, 3'd3, 16'd0},
            '{1'b1, 8'h00, 64'd6, 1'b1, 1'b1, 1'b1, 16'd4, 3'd3, 16'd0},
            '{1'b0, 8'h00, 64'd0, 1'b1, 1'b1, 1'b1, 16'd5, 3'd2, 16'd0},
            '{1'b0, 8'h00, 64'd0, 1'b1, 1'b1, 1'b1, 16'd6, 3'd1, 16'd0},
            '{1'b0, 8'h00, 64'd0, 1'b1, 1'b1, 1'b0, 16'd0, 3'd0, 16'd0},
            // address filter
            '{1'b1, 8'h00, 64'hABCD_0000_0000_000A, 1'b0, 1'b1, 1'b1, 16'd10, 3'd1, 16'd0},
            '{1'b1, 8'h01, 64'hFFFF_0000_0000_0063, 1'b0, 1'b1, 1'b1, 16'd10, 3'd1, 16'd1},
            '{1'b1, 8'h00, 64'd11,                  1'b0, 1'b1, 1'b1, 16'd10, 3'd2, 16'd1},
            '{1'b1, 8'h01, 64'd98,                  1'b0, 1'b1, 1'b1, 16'd10, 3'd2, 16'd2},
            '{1'b0, 8'h00, 64'd0,                   1'b1, 1'b1, 1'b1, 16'd11, 3'd1, 16'd2},
            '{1'b0, 8'h00, 64'd0,                   1'b1, 1'b1, 1'b0, 16'd0,  3'd0, 16'd2}
        };

        arstn = 1'b0;
        tdata = '0; tvalid = 1'b0; src = 8'h00; dst = 8'h00; o_ready = 1'b0;
        s_tdata = '0; s_tvalid = 1'b0; s_src = 8'h00; s_dst = 8'h00; s_oready = 1'b0;

        cycle();
        cycle();
        check_main("reset", 1'b0, 1'b0, 16'h0, 3'd0, 16'd0);

        arstn = 1'b1;
        #1;
        check("bringup tready before edge", 64'(tready), 64'd0);
        cycle();
        check("bringup tready after edge", 64'(tready), 64'd1);

        foreach (vecs[i]) begin
            tvalid  = vecs[i].valid;
            dst     = vecs[i].dst;
            tdata   = vecs[i].data;
            o_ready = vecs[i].rdy;
            cycle();
            check_main($sformatf("vec%0d", i), vecs[i].e_tready, vecs[i].e_tvalid,
                       vecs[i].e_tdata, vecs[i].e_level, vecs[i].e_drop);
        end

        // Sustained streaming: every edge pushes i and pops i-1.
        dst = 8'h00;
        o_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tvalid = 1'b1;
            tdata  = 64'(i);
            cycle();
            check_main($sformatf("stream%0d", i), 1'b1, 1'b1, 16'(i), 3'd1, 16'd2);
        end
        tvalid = 1'b0;
        cycle();
        check_main("stream drain", 1'b1, 1'b0, 16'h0, 3'd0, 16'd2);

        // Mid-stream reset with three words buffered.
        o_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tvalid = 1'b1;
            tdata  = 64'(16'h31 + i);
            cycle();
        end
        check_main("pre-reset", 1'b1, 1'b1, 16'h31, 3'd3, 16'd2);
        tvalid = 1'b0;
        arstn  = 1'b0;
        #1;
        check_main("mid reset", 1'b0, 1'b0, 16'h0, 3'd0, 16'd0);
        cycle();
        arstn = 1'b1;
        #1;
        check("post-reset tready before edge", 64'(tready), 64'd0);
        cycle();
        check_main("post-reset idle", 1'b1, 1'b0, 16'h0, 3'd0, 16'd0);
        tvalid = 1'b1;
        tdata  = 64'h77;
        cycle();
        check_main("post-reset flit", 1'b1, 1'b1, 16'h77, 3'd1, 16'd0);
        tvalid  = 1'b0;
        o_ready = 1'b1;
        cycle();
        check_main("post-reset drain", 1'b1, 1'b0, 16'h0, 3'd0, 16'd0);

        // Drop saturation with source checking on the second instance.
        force u_src.drop_q = 16'hFFFE;
        cycle();
        release u_src.drop_q;
        #1;
        check("sat preload", 64'(s_drop), 64'hFFFE);
        s_dst = 8'h00;
        s_src = 8'h06;
        for (int i = 0; i < 3; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 64'(16'h60 + i);
            cycle();
            check($sformatf("sat drop%0d", i), 64'(s_drop), 64'hFFFF);
            check($sformatf("sat tready%0d", i), 64'(s_tready), 64'd1);
            check($sformatf("sat level%0d", i), 64'(s_level), 64'd0);
            check($sformatf("sat tvalid%0d", i), 64'(s_ovalid), 64'd0);
        end
        s_src   = 8'h05;
        s_tdata = 64'hCAFE_0000_0000_0055;
        cycle();
        s_tvalid = 1'b0;
        check("src ok tvalid", 64'(s_ovalid), 64'd1);
        check("src ok ce", 64'(s_ce), 64'd1);
        check("src ok tdata", 64'(s_odata), 64'h55);
        check("src ok level", 64'(s_level), 64'd1);
        check("src ok drop held", 64'(s_drop), 64'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
